// File: rtl/branch_resolve_pkg.sv
// Shared codes for the EX-stage branch resolution unit: branch types, FSM
// states, hold encoding and flush length default.
package branch_resolve_pkg;
  localparam int HOLD_W = 3;
  localparam logic [HOLD_W-1:0] HOLD_CODE_NOPE = '0;

  localparam int FLUSH_CYC_DEFAULT = 2;
  localparam int CNT_W             = 3;

  localparam logic JMP_EN  = 1'b1;
  localparam logic JMP_DIS = 1'b0;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_e;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_e;
endpackage

// File: rtl/branch_resolve_if.sv
// Fetch prediction, EX operand and resolution signals of branch_resolve.
interface branch_resolve_if #(parameter int ADDR_W = 32);
  import branch_resolve_pkg::*;

  logic [HOLD_W-1:0] hold_code;
  logic              if_valid_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic              if_pred_taken_i;
  logic [ADDR_W-1:0] if_pred_target_i;
  logic              ex_valid_i;
  logic [ADDR_W-1:0] ex_pc_i;
  logic [3:0]        ex_br_type_i;
  logic [ADDR_W-1:0] ex_rs1_i;
  logic [ADDR_W-1:0] ex_rs2_i;
  logic [ADDR_W-1:0] ex_imm_i;
  logic [ADDR_W-1:0] pc_jmp_o;
  logic [ADDR_W-1:0] target_pc_o;
  logic              jmp_en_o;
  logic              redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              flush_o;

  modport master (
    output hold_code, if_valid_i, if_pc_i, if_pred_taken_i, if_pred_target_i,
           ex_valid_i, ex_pc_i, ex_br_type_i, ex_rs1_i, ex_rs2_i, ex_imm_i,
    input  pc_jmp_o, target_pc_o, jmp_en_o, redirect_o, redirect_pc_o, flush_o
  );

  modport slave (
    input  hold_code, if_valid_i, if_pc_i, if_pred_taken_i, if_pred_target_i,
           ex_valid_i, ex_pc_i, ex_br_type_i, ex_rs1_i, ex_rs2_i, ex_imm_i,
    output pc_jmp_o, target_pc_o, jmp_en_o, redirect_o, redirect_pc_o, flush_o
  );
endinterface

// File: rtl/branch_resolve_br_cmp.sv
// Combinational branch evaluator: actual taken flag and target for one EX op.
module br_cmp
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        br_type,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] reg_sum;

  assign pc_rel  = pc + imm;
  assign reg_sum = rs1 + imm;

  always_comb begin
    taken  = JMP_DIS;
    target = pc_rel;
    case (br_type)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 <  rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      BR_JAL:  taken = JMP_EN;
      BR_JALR: begin
        taken  = JMP_EN;
        target = {reg_sum[ADDR_W-1:1], 1'b0};
      end
      default: taken = JMP_DIS;
    endcase
  end
endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: shadows fetch predictions down to EX,
// checks them against the real outcome, redirects/flushes and feeds btb_ctrl.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  branch_resolve_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } shadow_t;

  shadow_t           s_id, s_ex;
  br_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              redirect_q, redirect_nx;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [ADDR_W-1:0] pc_jmp_q, target_pc_q;
  logic              jmp_en_q;
  logic              held, flushing, train_en;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              act_taken;
  logic [ADDR_W-1:0] act_target, corr_pc;
  logic              mispredict;

  br_cmp #(.ADDR_W(ADDR_W)) u_cmp (
    .br_type (bus.ex_br_type_i),
    .rs1     (bus.ex_rs1_i),
    .rs2     (bus.ex_rs2_i),
    .pc      (bus.ex_pc_i),
    .imm     (bus.ex_imm_i),
    .taken   (act_taken),
    .target  (act_target)
  );

  assign held     = (bus.hold_code != HOLD_CODE_NOPE);
  assign flushing = (state == BR_FLUSH);

  // A prediction only counts if the shadow slot really belongs to this EX op.
  assign pred_hit    = s_ex.v && (s_ex.pc == bus.ex_pc_i);
  assign pred_taken  = pred_hit & s_ex.taken;
  assign pred_target = pred_hit ? s_ex.target : '0;

  assign mispredict = bus.ex_valid_i &
                      ((pred_taken != act_taken) |
                       (act_taken & (pred_target != act_target)));
  assign corr_pc    = act_taken ? act_target : bus.ex_pc_i + ADDR_W'(4);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    redirect_nx = 1'b0;
    train_en    = 1'b0;
    case (state)
      BR_IDLE: begin
        if (!held) begin
          train_en = bus.ex_valid_i;
          if (mispredict) begin
            state_nx    = BR_FLUSH;
            cnt_nx      = CNT_W'(FLUSH_CYC);
            redirect_nx = 1'b1;
          end
        end
      end
      BR_FLUSH: begin
        // Flush length is fixed in cycles, so the count ignores hold.
        if (cnt == CNT_W'(1)) begin
          state_nx = BR_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BR_IDLE;
      cnt           <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      redirect_q <= redirect_nx;
      if (redirect_nx) redirect_pc_q <= corr_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_id <= '0;
      s_ex <= '0;
    end else begin
      if (!held) begin
        s_ex <= s_id;
        s_id <= '{v: bus.if_valid_i, pc: bus.if_pc_i,
                  taken: bus.if_pred_taken_i, target: bus.if_pred_target_i};
      end
      if (flushing) begin
        s_ex.v <= 1'b0;
        s_id.v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_jmp_q    <= '0;
      target_pc_q <= '0;
      jmp_en_q    <= JMP_DIS;
    end else if (train_en) begin
      pc_jmp_q    <= bus.ex_pc_i;
      jmp_en_q    <= act_taken;
      target_pc_q <= act_taken ? act_target : '0;
    end
  end

  assign bus.pc_jmp_o      = pc_jmp_q;
  assign bus.target_pc_o   = target_pc_q;
  assign bus.jmp_en_o      = jmp_en_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.flush_o       = flushing;
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed test-plan cases plus random traffic,
// all checked each cycle against a behavioural model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_on  = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_if #(.ADDR_W(32)) bus ();

  branch_resolve #(.ADDR_W(32), .FLUSH_CYC(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_sh[2];   // [0] = ID slot, [1] = EX slot
  int          flush_left = 0;
  logic        m_redir = 0, m_jen = 0;
  logic [31:0] m_rpc = 0, m_pcj = 0, m_tpc = 0;
  bit          m_held, a_tk, p_tk, m_mis;
  logic [31:0] a_tg, p_tg;

  function automatic void actual(input logic [3:0] t, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm,
                                 output bit tk, output logic [31:0] tg);
    tg = pc + imm;
    tk = 1'b0;
    case (t)
      4'd1: tk = (rs1 == rs2);
      4'd2: tk = (rs1 != rs2);
      4'd3: tk = ($signed(rs1) <  $signed(rs2));
      4'd4: tk = ($signed(rs1) >= $signed(rs2));
      4'd5: tk = (rs1 <  rs2);
      4'd6: tk = (rs1 >= rs2);
      4'd7: tk = 1'b1;
      4'd8: begin tk = 1'b1; tg = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: tk = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sh[0] = '{0, 0, 0, 0};
      m_sh[1] = '{0, 0, 0, 0};
      flush_left = 0;
      m_redir = 0; m_rpc = 0; m_pcj = 0; m_tpc = 0; m_jen = 0;
    end else begin
      m_held  = (bus.hold_code != 0);
      m_redir = 0;
      if (flush_left > 0) begin
        flush_left--;
        if (!m_held) begin
          m_sh[1] = m_sh[0];
          m_sh[0] = '{bus.if_valid_i, bus.if_pc_i, bus.if_pred_taken_i, bus.if_pred_target_i};
        end
        m_sh[0].v = 0;
        m_sh[1].v = 0;
      end else if (!m_held) begin
        actual(bus.ex_br_type_i, bus.ex_pc_i, bus.ex_rs1_i, bus.ex_rs2_i,
               bus.ex_imm_i, a_tk, a_tg);
        if (m_sh[1].v && m_sh[1].pc == bus.ex_pc_i) begin
          p_tk = m_sh[1].taken; p_tg = m_sh[1].tgt;
        end else begin
          p_tk = 0; p_tg = 0;
        end
        m_mis = bus.ex_valid_i && ((p_tk != a_tk) || (a_tk && p_tg != a_tg));
        if (bus.ex_valid_i) begin
          m_pcj = bus.ex_pc_i;
          m_jen = a_tk;
          m_tpc = a_tk ? a_tg : 32'h0;
        end
        if (m_mis) begin
          m_redir    = 1;
          m_rpc      = a_tk ? a_tg : bus.ex_pc_i + 32'd4;
          flush_left = FC;
        end
        m_sh[1] = m_sh[0];
        m_sh[0] = '{bus.if_valid_i, bus.if_pc_i, bus.if_pred_taken_i, bus.if_pred_target_i};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("redirect_o",    32'(bus.redirect_o),  32'(m_redir));
      chk("redirect_pc_o", bus.redirect_pc_o,    m_rpc);
      chk("flush_o",       32'(bus.flush_o),     32'(flush_left > 0));
      chk("pc_jmp_o",      bus.pc_jmp_o,         m_pcj);
      chk("target_pc_o",   bus.target_pc_o,      m_tpc);
      chk("jmp_en_o",      32'(bus.jmp_en_o),    32'(m_jen));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit ifv, input logic [31:0] ifpc, input bit pt,
                      input logic [31:0] ptg, input bit exv, input logic [31:0] expc,
                      input logic [3:0] ty, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im, input logic [HOLD_W-1:0] hc);
    bus.if_valid_i = ifv;  bus.if_pc_i = ifpc;
    bus.if_pred_taken_i = pt; bus.if_pred_target_i = ptg;
    bus.ex_valid_i = exv;  bus.ex_pc_i = expc; bus.ex_br_type_i = ty;
    bus.ex_rs1_i = r1; bus.ex_rs2_i = r2; bus.ex_imm_i = im;
    bus.hold_code = hc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_imm(input int k);
    case (k)
      0: return 32'hFFFF_FFF8;
      1: return 32'h4;
      2: return 32'h8;
      default: return 32'h20;
    endcase
  endfunction

  function automatic logic [31:0] pick_rs(input int k);
    case (k)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      default: return 32'h5;
    endcase
  endfunction

  initial begin
    rst_n = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_on = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst redirect", 32'(bus.redirect_o), 0);
    chk("rst flush",    32'(bus.flush_o),    0);
    chk("rst pc_jmp",   bus.pc_jmp_o,        0);
    rst_n = 1;

    // correct BEQ prediction
    step(1, 32'h100, 1, 32'h120, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 32'h100, 4'd1, 5, 5, 32'h20, 0);
    chk("beq redirect", 32'(bus.redirect_o), 0);
    chk("beq pc_jmp",   bus.pc_jmp_o,        32'h100);
    chk("beq target",   bus.target_pc_o,     32'h120);
    chk("beq jmp_en",   32'(bus.jmp_en_o),   1);

    // missed taken BNE
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 32'h200, 4'd2, 1, 2, 32'hFFFF_FFF8, 0);
    chk("bne redirect",    32'(bus.redirect_o), 1);
    chk("bne redirect_pc", bus.redirect_pc_o,   32'h1F8);
    chk("bne flush1",      32'(bus.flush_o),    1);
    idle(1);
    chk("bne strobe end",  32'(bus.redirect_o), 0);
    chk("bne flush2",      32'(bus.flush_o),    1);
    idle(1);
    chk("bne flush done",  32'(bus.flush_o),    0);
    idle(1);

    // wrong taken BLTU
    step(1, 32'h300, 1, 32'h340, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 32'h300, 4'd5, 32'hFFFF_FFFF, 1, 32'h40, 0);
    chk("bltu redirect_pc", bus.redirect_pc_o,  32'h304);
    chk("bltu jmp_en",      32'(bus.jmp_en_o),  0);
    chk("bltu target",      bus.target_pc_o,    0);
    idle(3);

    // wrong JALR target
    step(1, 32'h400, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 32'h400, 4'd8, 32'h1001, 0, 32'h2, 0);
    chk("jalr redirect",    32'(bus.redirect_o), 1);
    chk("jalr redirect_pc", bus.redirect_pc_o,   32'h1002);
    idle(3);

    // mispredict under a 3-cycle hold
    step(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 32'h600, 4'd2, 1, 2, 32'h10, 3'd2);
      chk("hold redirect", 32'(bus.redirect_o), 0);
      chk("hold pc_jmp",   bus.pc_jmp_o,        32'h400);
    end
    step(0, 0, 0, 0, 1, 32'h600, 4'd2, 1, 2, 32'h10, 0);
    chk("hold release redirect", 32'(bus.redirect_o), 1);
    chk("hold release pc",       bus.redirect_pc_o,   32'h610);
    idle(3);

    // tag mismatch, then reset on the first flush cycle
    step(1, 32'h500, 1, 32'h540, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 32'h504, 4'd7, 0, 0, 32'h3C, 0);
    chk("tag redirect",    32'(bus.redirect_o), 1);
    chk("tag redirect_pc", bus.redirect_pc_o,   32'h540);
    rst_n = 0;
    idle(1);
    chk("rst mid flush", 32'(bus.flush_o), 0);
    rst_n = 1;
    idle(1);

    // random traffic over a small PC window so tags hit often
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ipc, epc, pimm;
      ipc  = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      epc  = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      pimm = pick_imm($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0, ipc, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) != 0) ? ipc + pimm : $urandom,
           $urandom_range(0, 3) != 0, epc, 4'($urandom_range(0, 15)),
           pick_rs($urandom_range(0, 3)), pick_rs($urandom_range(0, 3)),
           pick_imm($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
    end
    rst_n = 1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
